// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the program-counter controller: word width,
// default reset/trap vectors, the controller state type and a small
// alignment helper.
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

   localparam int          WORD_W           = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } pc_state_t;

   // True when an address is not on a 4-byte instruction boundary.
   function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_incr.sv
// ---------------------------------------------------------------------------
// pc_incr
// 32-bit +4 incrementer; wraps modulo 2^32 with no carry-out flag.
// Ports:
//   pc        in  WORD_W  current program counter
//   pc_plus4  out WORD_W  pc + 4
// ---------------------------------------------------------------------------
module pc_incr
   import pc_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4
);

   assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_controller.sv
// ---------------------------------------------------------------------------
// pc_controller
// Instruction-fetch program-counter controller with BOOT/FETCH/HOLD
// sequencing, jump/branch redirects and an accepted-instruction counter.
//
// Configuration macro: PC_ALIGN_CHECK_EN
//   defined   : misaligned redirect target loads TRAP_VECTOR, sets sticky
//               AlignErr and still flushes.
//   undefined : redirect target low two bits are cleared; AlignErr is 0.
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   synchronous active-high reset
//   Stall        in   downstream cannot take an instruction
//   Jump         in   unconditional redirect (beats BranchTaken)
//   JumpTarget   in   jump destination
//   BranchTaken  in   taken-branch redirect
//   BranchTarget in   branch destination
//   FetchAck     in   memory returned word at FetchAddr (used in FETCH only)
//   FetchReq     out  fetch request
//   FetchAddr    out  current PC
//   PCPlus4      out  FetchAddr + 4
//   InstrValid   out  fetched word accepted this cycle
//   Flush        out  redirect applied this cycle
//   FetchCount   out  number of InstrValid pulses (wraps)
//   AlignErr     out  sticky misaligned-target flag
// ---------------------------------------------------------------------------
module pc_controller
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Jump,
   input  logic [WORD_W-1:0] JumpTarget,
   input  logic              BranchTaken,
   input  logic [WORD_W-1:0] BranchTarget,
   input  logic              FetchAck,
   output logic              FetchReq,
   output logic [WORD_W-1:0] FetchAddr,
   output logic [WORD_W-1:0] PCPlus4,
   output logic              InstrValid,
   output logic              Flush,
   output logic [WORD_W-1:0] FetchCount,
   output logic              AlignErr
);

   pc_state_t         state;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_next_seq;
   logic [WORD_W-1:0] fetch_count;
   logic              fetch_req;
   logic              align_err;

   logic              redirect;
   logic              advance;
   logic              misaligned;
   logic [WORD_W-1:0] sel_target;
   logic [WORD_W-1:0] redirect_pc;

   pc_incr u_pc_incr (
      .pc       (pc),
      .pc_plus4 (pc_next_seq)
   );

   // Redirect selection and same-cycle accept/flush decode; reset masks both.
   always_comb begin
      redirect   = 1'b0;
      advance    = 1'b0;
      sel_target = Jump ? JumpTarget : BranchTarget;
      if (Reset) begin
         redirect = 1'b0;
         advance  = 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               redirect = Jump | BranchTaken;
               advance  = ~(Jump | BranchTaken) & FetchAck & ~Stall;
            end
            ST_HOLD: begin
               redirect = Jump | BranchTaken;
               advance  = ~(Jump | BranchTaken) & ~Stall;
            end
            default: begin
               redirect = 1'b0;
               advance  = 1'b0;
            end
         endcase
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned  = is_misaligned(sel_target);
   assign redirect_pc = misaligned ? TRAP_VECTOR : sel_target;
`else
   // Low bits are discarded, so the trap vector and target bits [1:0] are
   // intentionally unused in this build.
   logic [WORD_W+1:0] unused_cfg;
   assign unused_cfg  = {TRAP_VECTOR, sel_target[1:0]};
   assign misaligned  = 1'b0;
   assign redirect_pc = {sel_target[WORD_W-1:2], 2'b00};
`endif

   // Controller state machine, PC, counter and sticky alignment flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_BOOT;
         pc          <= RESET_VECTOR;
         fetch_count <= 32'd0;
         fetch_req   <= 1'b0;
         align_err   <= 1'b0;
      end else begin
         if (advance) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (redirect && misaligned) begin
            align_err <= 1'b1;
         end
         case (state)
            ST_BOOT: begin
               state     <= ST_FETCH;
               fetch_req <= 1'b1;
            end
            ST_FETCH: begin
               if (redirect) begin
                  pc <= redirect_pc;
               end else if (advance) begin
                  pc <= pc_next_seq;
               end else if (FetchAck && Stall) begin
                  state     <= ST_HOLD;
                  fetch_req <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pc        <= redirect_pc;
                  state     <= ST_FETCH;
                  fetch_req <= 1'b1;
               end else if (advance) begin
                  pc        <= pc_next_seq;
                  state     <= ST_FETCH;
                  fetch_req <= 1'b1;
               end
            end
            default: begin
               state     <= ST_BOOT;
               fetch_req <= 1'b0;
            end
         endcase
      end
   end

   // Request is dropped combinationally while reset is held mid-fetch.
   assign FetchReq   = fetch_req & ~Reset;
   assign FetchAddr  = pc;
   assign PCPlus4    = pc_next_seq;
   assign InstrValid = advance;
   assign Flush      = redirect;
   assign FetchCount = fetch_count;
`ifdef PC_ALIGN_CHECK_EN
   assign AlignErr   = align_err;
`else
   logic unused_align;
   assign unused_align = align_err;
   assign AlignErr     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// ---------------------------------------------------------------------------
// tb_pc_controller
// Self-checking bench: directed scenarios followed by random stimulus, all
// outputs compared every cycle against a behavioural model of the fetch
// rules (phase, PC, counter, sticky error).
// ---------------------------------------------------------------------------
module tb_pc_controller;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0080;
`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1, Stall = 1'b0, Jump = 1'b0, BranchTaken = 1'b0, FetchAck = 1'b0;
   logic [31:0] JumpTarget = 32'd0, BranchTarget = 32'd0;
   logic        FetchReq, InstrValid, Flush, AlignErr;
   logic [31:0] FetchAddr, PCPlus4, FetchCount;

   int total = 0;
   int bad   = 0;

   // model: 0 = boot, 1 = fetching, 2 = holding an accepted-but-stalled word
   int          m_phase = 0;
   logic [31:0] m_pc    = 32'd0;
   logic [31:0] m_cnt   = 32'd0;
   logic        m_err   = 1'b0;
   bit          m_known = 1'b0;

   pc_controller #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .FetchAck(FetchAck),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .PCPlus4(PCPlus4),
      .InstrValid(InstrValid), .Flush(Flush), .FetchCount(FetchCount), .AlignErr(AlignErr)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, check against the model, then advance it.
   task automatic step(input logic r, input logic s, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic a);
      bit          redir, acc;
      logic [31:0] tgt;
      @(negedge Clk);
      Reset = r; Stall = s; Jump = j; JumpTarget = jt;
      BranchTaken = b; BranchTarget = bt; FetchAck = a;
      #1;
      redir = !r && (m_phase != 0) && (j || b);
      acc   = !r && !redir && ((m_phase == 1 && a && !s) || (m_phase == 2 && !s));
      check("req",   32'(FetchReq),   32'(!r && m_phase == 1));
      check("valid", 32'(InstrValid), 32'(acc));
      check("flush", 32'(Flush),      32'(redir));
      if (m_known) begin
         check("addr",  FetchAddr,      m_pc);
         check("plus4", PCPlus4,        m_pc + 32'd4);
         check("count", FetchCount,     m_cnt);
         check("aerr",  32'(AlignErr),  32'(m_err));
      end
      @(posedge Clk);
      if (r) begin
         m_pc = RV; m_phase = 0; m_cnt = 32'd0; m_err = 1'b0; m_known = 1'b1;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (redir) begin
         tgt = j ? jt : bt;
         if (ALIGN_EN && (tgt % 4) != 0) begin
            m_pc  = TV;
            m_err = 1'b1;
         end else begin
            m_pc = tgt - (tgt % 4);
         end
         m_phase = 1;
      end else if (acc) begin
         m_pc    = m_pc + 32'd4;
         m_cnt   = m_cnt + 32'd1;
         m_phase = 1;
      end else if (m_phase == 1 && a && s) begin
         m_phase = 2;
      end
   endtask

   task automatic idle(input logic s, input logic a);
      step(1'b0, s, 1'b0, 32'd0, 1'b0, 32'd0, a);
   endtask

   initial begin
      // two reset cycles, one boot cycle (ack ignored there)
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      idle(1'b0, 1'b1);
      #1 check("boot_exit_addr", FetchAddr, 32'd0);
      check("boot_exit_req", 32'(FetchReq), 32'd1);

      // three back-to-back accepted fetches
      repeat (3) idle(1'b0, 1'b1);
      #1 check("seq_addr", FetchAddr, 32'h0000_000C);
      check("seq_cnt", FetchCount, 32'd3);

      // ack with stall -> hold, then release
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);
      #1 check("hold_addr", FetchAddr, 32'h0000_000C);
      check("hold_req", 32'(FetchReq), 32'd0);
      idle(1'b0, 1'b0);
      #1 check("release_addr", FetchAddr, 32'h0000_0010);
      check("release_cnt", FetchCount, 32'd4);

      // jump beats branch, with ack in the same cycle
      step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1);
      #1 check("jump_prio_addr", FetchAddr, 32'h0000_0100);
      check("jump_prio_cnt", FetchCount, 32'd4);

      // PC wrap at the top of the address space
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0);
      idle(1'b0, 1'b1);
      #1 check("pc_wrap", FetchAddr, 32'h0000_0000);

      // counter wrap from a preset value
      force dut.fetch_count = 32'hFFFF_FFFE;
      #1 release dut.fetch_count;
      m_cnt = 32'hFFFF_FFFE;
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      #1 check("cnt_wrap", FetchCount, 32'h0000_0000);

      // misaligned branch target
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0102, 1'b0);
      #1 check("misalign_addr", FetchAddr, ALIGN_EN ? TV : 32'h0000_0100);
      check("misalign_err", 32'(AlignErr), 32'(ALIGN_EN));
      repeat (3) idle(1'b0, 1'b1);
      #1 check("err_sticky", 32'(AlignErr), 32'(ALIGN_EN));

      // reset clears the flag; a redirect during boot is ignored
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      #1 check("rst_err", 32'(AlignErr), 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'd0, 1'b0);
      #1 check("boot_redirect_ignored", FetchAddr, RV);

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, $urandom,
              $urandom_range(0, 5) == 0, $urandom,
              $urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_controller.md
PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080, PC loaded on misaligned redirect (PC_ALIGN_CHECK_EN only).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Stall  in  1  downstream cannot accept an instruction this cycle.
REQ-006 Jump  in  1  unconditional redirect request.
REQ-007 JumpTarget  in  32  jump destination.
REQ-008 BranchTaken  in  1  taken-branch redirect request.
REQ-009 BranchTarget  in  32  branch destination.
REQ-010 FetchAck  in  1  instruction memory has returned the word at FetchAddr.
REQ-011 FetchReq  out  1  fetch request to instruction memory.
REQ-012 FetchAddr  out  32  current PC.
REQ-013 PCPlus4  out  32  FetchAddr + 4, combinational.
REQ-014 InstrValid  out  1  one-cycle pulse: fetched word accepted.
REQ-015 Flush  out  1  one-cycle pulse: redirect applied, in-flight fetch discarded.
REQ-016 FetchCount  out  32  count of InstrValid pulses.
REQ-017 AlignErr  out  1  sticky misaligned-target flag.

Function
REQ-018 States: BOOT, FETCH, HOLD; encoding is implementation-defined.
REQ-019 BOOT lasts exactly one cycle with FetchReq=0, then goes to FETCH unconditionally.
REQ-020 FETCH: FetchReq=1, FetchAddr=PC.
REQ-021 FETCH with FetchAck=1 and Stall=0: InstrValid=1, PC<=PC+4 next edge, stay FETCH.
REQ-022 FETCH with FetchAck=1 and Stall=1: InstrValid=0, PC held, next state HOLD.
REQ-023 HOLD: FetchReq=0; on Stall=0, InstrValid=1, PC<=PC+4, next state FETCH.
REQ-024 Redirect (Jump or BranchTaken) in FETCH or HOLD: PC<=target next edge, Flush=1, InstrValid=0, next state FETCH, regardless of FetchAck/Stall.
REQ-025 Priority: Reset > Jump > BranchTaken > sequential advance.
REQ-026 Redirect in BOOT is ignored.
REQ-027 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-028 FetchCount increments by 1 on every InstrValid pulse and wraps from 32'hFFFF_FFFF to 0.
REQ-029 FetchAck is ignored outside FETCH.

Reset
REQ-030 Reset=1 at an edge: PC<=RESET_VECTOR, state<=BOOT, FetchCount<=0, AlignErr<=0.
REQ-031 During reset and in BOOT: FetchReq=0, InstrValid=0, Flush=0.
REQ-032 Reset asserted mid-fetch or mid-hold aborts the operation; no InstrValid or Flush is generated in that cycle.

Configuration
REQ-033 Macro PC_ALIGN_CHECK_EN defined: a selected redirect target with bits [1:0] != 0 loads TRAP_VECTOR instead, sets AlignErr (sticky until reset), and pulses Flush.
REQ-034 Macro PC_ALIGN_CHECK_EN undefined: redirect target bits [1:0] are forced to 00, and AlignErr is tied to 0.

Structure
REQ-035 Shared package pc_ctrl_pkg holds the state type, the default RESET_VECTOR/TRAP_VECTOR constants, and the word width (32).
REQ-036 Sub-module pc_incr (32-bit +4 incrementer) drives PCPlus4 and the sequential next-PC value.

Verification
REQ-037 Reset 2 cycles, release -> 1 BOOT cycle with FetchReq=0, then FetchReq=1, FetchAddr=0.
REQ-038 FetchAck=1 held, Stall=0 for 3 cycles -> FetchAddr 0,4,8,C; 3 InstrValid pulses; FetchCount=3.
REQ-039 Ack with Stall=1 for 2 cycles, then Stall=0 -> HOLD with FetchReq=0 and PC held; single InstrValid on release; PC advances by 4.
REQ-040 Jump=1 to 32'h100 and BranchTaken=1 to 32'h200 in the same cycle as FetchAck -> Flush=1, InstrValid=0, next FetchAddr=32'h100.
REQ-041 PC=32'hFFFF_FFFC, ack -> FetchAddr=0; FetchCount preset near 32'hFFFF_FFFF wraps to 0.
REQ-042 With PC_ALIGN_CHECK_EN, branch to 32'h102 -> FetchAddr=TRAP_VECTOR and AlignErr=1 until reset; without the macro -> FetchAddr=32'h100 and AlignErr=0.
